// File: rtl/branch_predictor.sv
// branch_predictor: dynamic branch predictor for the 5-stage RV32 pipeline.
//   IF side : pc_if_i looked up combinationally in a direct-mapped BTB
//             (2-bit counters) and a return-address stack. The result is
//             pred_taken_o and pred_target_o (pc_if_i+4 when not taken).
//   EX side : upd_* describe a resolved control-flow instruction. The BTB,
//             the RAS and the mispredict counter are updated on the rising edge.
//   clear_i : invalidates the BTB and empties the RAS (fence.i). It wins over a
//             simultaneous update.
//   ras_count_o    : live RAS occupancy.
//   perf_mispred_o : saturating count of mispredicted resolutions.
module branch_predictor #(
  parameter int XLEN      = 32,
  parameter int ENTRIES   = 64,
  parameter int TAG_W     = 8,
  parameter int RAS_DEPTH = 4,
  parameter int PERF_W    = 32,
  localparam int CNT_W    = $clog2(RAS_DEPTH+1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [XLEN-1:0]   pc_if_i,
  output logic              pred_taken_o,
  output logic [XLEN-1:0]   pred_target_o,
  input  logic              upd_valid_i,
  input  logic [XLEN-1:0]   upd_pc_i,
  input  logic              upd_is_branch_i,
  input  logic [1:0]        upd_jump_type_i,
  input  logic [4:0]        upd_rd_i,
  input  logic [4:0]        upd_rs1_i,
  input  logic              upd_taken_i,
  input  logic [XLEN-1:0]   upd_target_i,
  input  logic              upd_mispred_i,
  input  logic              clear_i,
  output logic [CNT_W-1:0]  ras_count_o,
  output logic [PERF_W-1:0] perf_mispred_o
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

  typedef enum logic [1:0] {T_BR, T_JAL, T_JALR, T_RET} btype_e;

  // BTB storage: only the valid bits need a reset value.
  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q  [ENTRIES];
  logic [XLEN-1:0]    tgt_q  [ENTRIES];
  btype_e             type_q [ENTRIES];
  logic [1:0]         cnt_q  [ENTRIES];

  // RAS: ras_ptr_q is the next free slot, the top lives one below it.
  logic [XLEN-1:0]    ras_q [RAS_DEPTH];
  logic [PTR_W-1:0]   ras_ptr_q, ras_ptr_d, ras_top, ras_inc;
  logic [CNT_W-1:0]   ras_cnt_q, ras_cnt_d;
  logic               ras_we;
  logic [PTR_W-1:0]   ras_widx;

  logic [PERF_W-1:0]  perf_q;

  assign ras_top = (ras_ptr_q == '0) ? PTR_W'(RAS_DEPTH-1) : ras_ptr_q - 1'b1;
  assign ras_inc = (ras_ptr_q == PTR_W'(RAS_DEPTH-1)) ? '0 : ras_ptr_q + 1'b1;

  // ---------------- IF-side lookup ----------------
  logic [IDX_W-1:0] l_idx;
  logic [TAG_W-1:0] l_tag;
  logic             l_hit;

  assign l_idx = pc_if_i[IDX_W+1:2];
  assign l_tag = pc_if_i[IDX_W+TAG_W+1:IDX_W+2];
  assign l_hit = valid_q[l_idx] && (tag_q[l_idx] == l_tag);

  always_comb begin
    pred_taken_o  = 1'b0;
    pred_target_o = pc_if_i + XLEN'(4);
    if (l_hit) begin
      case (type_q[l_idx])
        T_BR: if (cnt_q[l_idx][1]) begin
          pred_taken_o  = 1'b1;
          pred_target_o = tgt_q[l_idx];
        end
        T_JAL, T_JALR: begin
          pred_taken_o  = 1'b1;
          pred_target_o = tgt_q[l_idx];
        end
        T_RET: if (ras_cnt_q != '0) begin
          pred_taken_o  = 1'b1;
          pred_target_o = ras_q[ras_top];
        end
        default: ;
      endcase
    end
  end

  // ---------------- EX-side decode ----------------
  logic [IDX_W-1:0] u_idx;
  logic [TAG_W-1:0] u_tag;
  logic             u_hit, do_upd;
  logic             is_jal, is_jalr, is_jump, link_rd, link_rs1, is_call, is_ret;
  btype_e           u_type;

  assign u_idx    = upd_pc_i[IDX_W+1:2];
  assign u_tag    = upd_pc_i[IDX_W+TAG_W+1:IDX_W+2];
  assign u_hit    = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
  assign do_upd   = upd_valid_i && !clear_i;
  assign is_jal   = (upd_jump_type_i == 2'b01);
  assign is_jalr  = (upd_jump_type_i == 2'b10);
  assign is_jump  = is_jal || is_jalr;
  assign link_rd  = (upd_rd_i == 5'd1) || (upd_rd_i == 5'd5);
  assign link_rs1 = (upd_rs1_i == 5'd1) || (upd_rs1_i == 5'd5);
  assign is_call  = is_jump && link_rd;
  // jalr with rd==rs1 both link registers is a plain call (push), not a return.
  assign is_ret   = is_jalr && link_rs1 && !(link_rd && (upd_rd_i == upd_rs1_i));
  assign u_type   = is_ret ? T_RET : is_jalr ? T_JALR : is_jal ? T_JAL : T_BR;

  // BTB write enables
  logic       we_ent, we_tgt, we_cnt;
  logic [1:0] cnt_d;

  always_comb begin
    we_ent = 1'b0;
    we_tgt = 1'b0;
    we_cnt = 1'b0;
    cnt_d  = cnt_q[u_idx];
    if (do_upd) begin
      if (is_jump) begin
        we_ent = 1'b1;
        we_tgt = 1'b1;
        we_cnt = 1'b1;
        cnt_d  = 2'b11;
      end else if (upd_is_branch_i) begin
        if (u_hit) begin
          we_cnt = 1'b1;
          we_tgt = upd_taken_i;
          if (upd_taken_i) cnt_d = (cnt_q[u_idx] == 2'b11) ? 2'b11 : cnt_q[u_idx] + 2'd1;
          else             cnt_d = (cnt_q[u_idx] == 2'b00) ? 2'b00 : cnt_q[u_idx] - 2'd1;
        end else if (upd_taken_i) begin
          we_ent = 1'b1;
          we_tgt = 1'b1;
          we_cnt = 1'b1;
          cnt_d  = 2'b10;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       valid_q <= '0;
    else if (clear_i) valid_q <= '0;
    else if (we_ent)  valid_q[u_idx] <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (we_ent) begin
      tag_q[u_idx]  <= u_tag;
      type_q[u_idx] <= u_type;
    end
    if (we_tgt) tgt_q[u_idx] <= upd_target_i;
    if (we_cnt) cnt_q[u_idx] <= cnt_d;
  end

  // ---------------- RAS ----------------
  always_comb begin
    ras_we    = 1'b0;
    ras_widx  = ras_ptr_q;
    ras_ptr_d = ras_ptr_q;
    ras_cnt_d = ras_cnt_q;
    if (clear_i) begin
      ras_ptr_d = '0;
      ras_cnt_d = '0;
    end else if (do_upd) begin
      if (is_call && (!is_ret || ras_cnt_q == '0)) begin
        // push; when full the oldest slot is overwritten by wrapping
        ras_we    = 1'b1;
        ras_ptr_d = ras_inc;
        if (ras_cnt_q != CNT_W'(RAS_DEPTH)) ras_cnt_d = ras_cnt_q + 1'b1;
      end else if (is_call && is_ret) begin
        ras_we   = 1'b1;
        ras_widx = ras_top;
      end else if (is_ret && ras_cnt_q != '0) begin
        ras_ptr_d = ras_top;
        ras_cnt_d = ras_cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ras_ptr_q <= '0;
      ras_cnt_q <= '0;
    end else begin
      ras_ptr_q <= ras_ptr_d;
      ras_cnt_q <= ras_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (ras_we) ras_q[ras_widx] <= upd_pc_i + XLEN'(4);
  end

  // ---------------- perf counter ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) perf_q <= '0;
    else if (upd_valid_i && upd_mispred_i && perf_q != '1) perf_q <= perf_q + 1'b1;
  end

  assign ras_count_o    = ras_cnt_q;
  assign perf_mispred_o = perf_q;

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] pc_if_i = 32'h100;
  logic        pred_taken_o;
  logic [31:0] pred_target_o;
  logic        upd_valid_i = 1'b0;
  logic [31:0] upd_pc_i = '0;
  logic        upd_is_branch_i = 1'b0;
  logic [1:0]  upd_jump_type_i = '0;
  logic [4:0]  upd_rd_i = '0;
  logic [4:0]  upd_rs1_i = '0;
  logic        upd_taken_i = 1'b0;
  logic [31:0] upd_target_i = '0;
  logic        upd_mispred_i = 1'b0;
  logic        clear_i = 1'b0;
  logic [2:0]  ras_count_o;
  logic [31:0] perf_mispred_o;

  always #5 clk = ~clk;

  branch_predictor dut (
    .clk(clk), .rst_n(rst_n), .pc_if_i(pc_if_i),
    .pred_taken_o(pred_taken_o), .pred_target_o(pred_target_o),
    .upd_valid_i(upd_valid_i), .upd_pc_i(upd_pc_i),
    .upd_is_branch_i(upd_is_branch_i), .upd_jump_type_i(upd_jump_type_i),
    .upd_rd_i(upd_rd_i), .upd_rs1_i(upd_rs1_i), .upd_taken_i(upd_taken_i),
    .upd_target_i(upd_target_i), .upd_mispred_i(upd_mispred_i),
    .clear_i(clear_i), .ras_count_o(ras_count_o), .perf_mispred_o(perf_mispred_o)
  );

  typedef struct {
    logic        taken;
    logic [31:0] tgt;
    logic [2:0]  rasc;
    logic [31:0] perf;
  } exp_t;

  exp_t        expq[$];
  string       nameq[$];
  int          checks = 0;
  int          failures = 0;
  logic        chk = 1'b0;
  logic [31:0] exp_perf = '0;
  exp_t        me;
  string       mn;

  // Monitor: pops one expectation each cycle the stimulus presents a lookup.
  always @(negedge clk) begin
    if (chk) begin
      checks++;
      if (expq.size() == 0) begin
        failures++;
        $display("FAIL monitor: lookup presented with no expectation queued");
      end else begin
        me = expq.pop_front();
        mn = nameq.pop_front();
        if (pred_taken_o !== me.taken || pred_target_o !== me.tgt ||
            ras_count_o !== me.rasc || perf_mispred_o !== me.perf) begin
          failures++;
          $display("FAIL %s: got taken=%0b tgt=%h ras=%0d perf=%0d, want taken=%0b tgt=%h ras=%0d perf=%0d",
                   mn, pred_taken_o, pred_target_o, ras_count_o, perf_mispred_o,
                   me.taken, me.tgt, me.rasc, me.perf);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    upd_valid_i   = 1'b0;
    upd_mispred_i = 1'b0;
    clear_i       = 1'b0;
    chk           = 1'b0;
  endtask

  task automatic set_upd(input logic [31:0] pc, input logic br, input logic [1:0] jt,
                         input logic [4:0] rd, input logic [4:0] rs1, input logic tk,
                         input logic [31:0] tgt, input logic mis);
    upd_valid_i     = 1'b1;
    upd_pc_i        = pc;
    upd_is_branch_i = br;
    upd_jump_type_i = jt;
    upd_rd_i        = rd;
    upd_rs1_i       = rs1;
    upd_taken_i     = tk;
    upd_target_i    = tgt;
    upd_mispred_i   = mis;
  endtask

  task automatic br(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
    set_upd(pc, 1'b1, 2'b00, 5'd0, 5'd0, tk, tgt, 1'b0);
    tick();
  endtask

  task automatic jal(input logic [31:0] pc, input logic [4:0] rd, input logic [31:0] tgt);
    set_upd(pc, 1'b0, 2'b01, rd, 5'd0, 1'b1, tgt, 1'b0);
    tick();
  endtask

  task automatic jalr(input logic [31:0] pc, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [31:0] tgt);
    set_upd(pc, 1'b0, 2'b10, rd, rs1, 1'b1, tgt, 1'b0);
    tick();
  endtask

  task automatic check(input string nm, input logic [31:0] pc, input logic tk,
                       input logic [31:0] tgt, input logic [2:0] rasc);
    exp_t e;
    e.taken = tk;
    e.tgt   = tgt;
    e.rasc  = rasc;
    e.perf  = exp_perf;
    pc_if_i = pc;
    expq.push_back(e);
    nameq.push_back(nm);
    chk = 1'b1;
    tick();
  endtask

  initial begin
    tick();
    check("reset", 32'h100, 1'b0, 32'h104, 3'd0);
    rst_n = 1'b1;
    tick();

    // 2-bit counter walk on BEQ @0x200; not-taken updates carry a bogus target
    br(32'h200, 1'b1, 32'h180);
    check("br_alloc", 32'h200, 1'b1, 32'h180, 3'd0);
    br(32'h200, 1'b0, 32'h5A0);
    br(32'h200, 1'b0, 32'h5A0);
    check("cnt00", 32'h200, 1'b0, 32'h204, 3'd0);
    br(32'h200, 1'b0, 32'h5A0);          // clamps at 00
    br(32'h200, 1'b1, 32'h180);          // 01
    check("cnt_lo_clamp", 32'h200, 1'b0, 32'h204, 3'd0);
    br(32'h200, 1'b1, 32'h180);          // 10
    check("cnt10", 32'h200, 1'b1, 32'h180, 3'd0);
    br(32'h200, 1'b1, 32'h180);          // 11
    br(32'h200, 1'b1, 32'h180);          // stays 11
    br(32'h200, 1'b1, 32'h180);          // stays 11
    br(32'h200, 1'b0, 32'h5A0);          // 10
    check("cnt_hi_clamp", 32'h200, 1'b1, 32'h180, 3'd0);
    br(32'h200, 1'b0, 32'h5A0);          // 01
    check("cnt01", 32'h200, 1'b0, 32'h204, 3'd0);

    // not-taken miss never allocates; alias with same idx, other tag misses
    br(32'h300, 1'b0, 32'h5A0);
    check("nt_no_alloc", 32'h300, 1'b0, 32'h304, 3'd0);
    br(32'h300, 1'b1, 32'h340);
    check("alloc300", 32'h300, 1'b1, 32'h340, 3'd0);
    check("alias_miss", 32'h400, 1'b0, 32'h404, 3'd0);

    // call / return
    jal(32'h400, 5'd1, 32'h800);
    check("jal", 32'h400, 1'b1, 32'h800, 3'd1);
    jalr(32'h810, 5'd0, 5'd1, 32'h404);
    check("ret_now_empty", 32'h810, 1'b0, 32'h814, 3'd0);
    jal(32'h400, 5'd1, 32'h800);
    check("ret_pred", 32'h810, 1'b1, 32'h404, 3'd1);
    for (int i = 0; i < 4; i++) jal(32'h1080 + 32'(i*4), 5'd1, 32'h800);
    check("ras_full", 32'h810, 1'b1, 32'h1090, 3'd4);
    jalr(32'h810, 5'd0, 5'd1, 32'h1090);
    check("pop3", 32'h810, 1'b1, 32'h108C, 3'd3);
    jalr(32'h810, 5'd0, 5'd1, 32'h108C);
    check("pop2", 32'h810, 1'b1, 32'h1088, 3'd2);
    jalr(32'h810, 5'd0, 5'd1, 32'h1088);
    check("pop1", 32'h810, 1'b1, 32'h1084, 3'd1);
    jalr(32'h810, 5'd0, 5'd1, 32'h1084);
    check("oldest_lost", 32'h810, 1'b0, 32'h814, 3'd0);
    jalr(32'h810, 5'd0, 5'd1, 32'h1084);
    check("pop_empty", 32'h810, 1'b0, 32'h814, 3'd0);
    jalr(32'h820, 5'd1, 5'd5, 32'h900);  // call+ret on empty: push
    check("xchg_empty", 32'h810, 1'b1, 32'h824, 3'd1);
    jalr(32'h830, 5'd1, 5'd5, 32'h900);  // call+ret: replace top
    check("xchg_top", 32'h810, 1'b1, 32'h834, 3'd1);

    // mispredict counter
    for (int i = 0; i < 3; i++) begin
      set_upd(32'h0, 1'b0, 2'b00, 5'd0, 5'd0, 1'b0, 32'h0, 1'b1);
      tick();
    end
    exp_perf = 32'd3;
    check("perf3", 32'h100, 1'b0, 32'h104, 3'd1);

    // clear beats a simultaneous taken update
    set_upd(32'h900, 1'b1, 2'b00, 5'd0, 5'd0, 1'b1, 32'h200, 1'b0);
    clear_i = 1'b1;
    tick();
    check("clr_upd", 32'h900, 1'b0, 32'h904, 3'd0);
    check("clr_jal", 32'h400, 1'b0, 32'h404, 3'd0);
    check("clr_ret", 32'h810, 1'b0, 32'h814, 3'd0);

    // same-edge update and lookup
    set_upd(32'h200, 1'b1, 2'b00, 5'd0, 5'd0, 1'b1, 32'h180, 1'b0);
    check("same_old", 32'h200, 1'b0, 32'h204, 3'd0);
    check("same_new", 32'h200, 1'b1, 32'h180, 3'd0);

    tick();
    if (expq.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left, want 0", expq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
